// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus scheduler.
//   - FSM state encoding (plain localparams so older code can compare against them)
//   - HD44780-style init command bytes and the init sequence length
//   - DDRAM line address bases for text producers
//   - helpers: init command lookup and long-execution command detection
package lcd_pkg;

  localparam logic [2:0] StPwrup    = 3'd0;
  localparam logic [2:0] StInitLoad = 3'd1;
  localparam logic [2:0] StSetup    = 3'd2;
  localparam logic [2:0] StEpulse   = 3'd3;
  localparam logic [2:0] StHold     = 3'd4;
  localparam logic [2:0] StExec     = 3'd5;
  localparam logic [2:0] StIdle     = 3'd6;

  localparam logic [7:0] LCD_FUNC_SET = 8'h3C;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_HOME     = 8'h02;

  localparam int unsigned LCD_INIT_LEN = 4;

  localparam logic [7:0] LCD_LINE0_ADDR = 8'h80;
  localparam logic [7:0] LCD_LINE1_ADDR = 8'hC0;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_SET;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_ENTRY;
      default: cmd = LCD_CLEAR;
    endcase
    return cmd;
  endfunction

  // Clear and home (0x02 or 0x03, the low bit is don't-care) need the long wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CLEAR || data == LCD_HOME || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_bus_sched_if.sv
// Requester handshakes and LCD pin bundle for lcd_bus_sched.
//   req0_* / req1_* : valid, rs, data in; ready out (combinational accept)
//   init_done, busy : scheduler status
//   LCD_E/RS/RW/DATA: registered LCD write bus
// Modports: master = requester/pin-side view, slave = scheduler view.
interface lcd_bus_sched_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       init_done;
  logic       busy;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport master (
    output req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    input  req0_ready, req1_ready, init_done, busy, LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data, req1_valid, req1_rs, req1_data,
    output req0_ready, req1_ready, init_done, busy, LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );
endinterface

// File: rtl/lcd_rr_arb.sv
// Two-input round-robin arbiter.
//   clk, resetn : clock, synchronous active-high reset
//   valid[1:0]  : requesters with a pending write
//   accept      : a transfer happened this cycle; the granted requester becomes "last served"
//   grant[1:0]  : one-hot grant (all zero when nothing is valid)
module lcd_rr_arb (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // 1 = requester 1 was served last; reset value makes requester 0 win the first tie.
  logic last_q, last_d;

  always_comb begin
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (accept) last_d = grant[1];
  end

  always_ff @(posedge clk) begin
    if (resetn) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/lcd_bus_sched.sv
// Character-LCD write bus scheduler.
// After reset it idles the bus for T_POWERUP cycles, sends the four init commands, then
// serves two requesters round-robin. Every accepted byte becomes one timed write:
// SETUP (E low) -> EPULSE (E high) -> HOLD (E low) -> EXEC wait.
//   clk    : system clock
//   resetn : synchronous reset, active high
//   bus    : lcd_bus_sched_if.slave (requester handshakes, status, LCD pins)
module lcd_bus_sched
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP   = 70,
  parameter int unsigned T_SETUP     = 1,
  parameter int unsigned T_EPW       = 2,
  parameter int unsigned T_HOLD      = 1,
  parameter int unsigned T_EXEC      = 20,
  parameter int unsigned T_EXEC_LONG = 200
) (
  input  logic           clk,
  input  logic           resetn,
  lcd_bus_sched_if.slave bus
);

  localparam int unsigned CntMax = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            init_done_q, init_done_d;
  logic            e_q, e_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;

  logic [1:0]      grant;
  logic            idle;
  logic            xfer0, xfer1;
  logic [CntW-1:0] exec_last;

  assign idle  = (state_q == StIdle);
  assign xfer0 = bus.req0_valid && bus.req0_ready;
  assign xfer1 = bus.req1_valid && bus.req1_ready;

  lcd_rr_arb u_arb (
    .clk    (clk),
    .resetn (resetn),
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .accept (xfer0 || xfer1),
    .grant  (grant)
  );

  assign bus.req0_ready = idle && init_done_q && grant[0];
  assign bus.req1_ready = idle && init_done_q && grant[1];

  // Exec length follows the byte currently on the bus (it is held through EXEC).
  assign exec_last = is_long_cmd(rs_q, data_q) ? CntW'(T_EXEC_LONG - 1) : CntW'(T_EXEC - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    idx_d       = idx_q;
    init_done_d = init_done_q;
    e_d         = e_q;
    rs_d        = rs_q;
    data_d      = data_q;

    case (state_q)
      StPwrup: begin
        if (cnt_q == CntW'(T_POWERUP - 1)) begin
          state_d = StInitLoad;
          cnt_d   = '0;
        end
      end
      StInitLoad: begin
        rs_d    = 1'b0;
        data_d  = init_cmd(idx_q);
        state_d = StSetup;
        cnt_d   = '0;
      end
      StSetup: begin
        if (cnt_q == CntW'(T_SETUP - 1)) begin
          e_d     = 1'b1;
          state_d = StEpulse;
          cnt_d   = '0;
        end
      end
      StEpulse: begin
        if (cnt_q == CntW'(T_EPW - 1)) begin
          e_d     = 1'b0;
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (cnt_q == CntW'(T_HOLD - 1)) begin
          state_d = StExec;
          cnt_d   = '0;
        end
      end
      StExec: begin
        if (cnt_q == exec_last) begin
          cnt_d = '0;
          if (!init_done_q && idx_q != 2'(LCD_INIT_LEN - 1)) begin
            idx_d   = idx_q + 2'd1;
            state_d = StInitLoad;
          end else begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (xfer0) begin
          rs_d    = bus.req0_rs;
          data_d  = bus.req0_data;
          state_d = StSetup;
        end else if (xfer1) begin
          rs_d    = bus.req1_rs;
          data_d  = bus.req1_data;
          state_d = StSetup;
        end
      end
      default: begin
        e_d     = 1'b0;
        state_d = StPwrup;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= StPwrup;
      cnt_q       <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

  assign bus.init_done = init_done_q;
  assign bus.busy      = !idle;
  assign bus.LCD_E     = e_q;
  assign bus.LCD_RS    = rs_q;
  assign bus.LCD_RW    = 1'b0;
  assign bus.LCD_DATA  = data_q;

endmodule
